timing_counter_bank: RTL and testbench

Bank of `NUM_CTR` independent DDR timing-constraint trackers. Each tracker counts a run-time-programmable constraint length, in DDR clock cycles, and reports when it is met. The count is resolved to the `nCK_PER_CLK` command slots of each fabric cycle. The bank sits in the controller scheduler: one tracker per constraint or per bank (tRCD, tRP, tRAS, tWR, …). The command picker gates issue with `done` and places the command in slot `offset`.

---
 rtl/timing_counter_bank.sv | 123 ++++++++++++
 tb/tb_timing_counter_bank.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_counter_bank.sv
// -----------------------------------------------------------------------------
// timing_counter_bank
//
// Bank of NUM_CTR independent DDR timing-constraint trackers (tRCD, tRP, tRAS,
// tWR, ...). Each tracker holds a run-time programmable constraint length
// (tck) in DDR clock cycles and a remaining count (rem). rem is measured from
// slot 0 of the next fabric cycle. Each fabric cycle covers nCK_PER_CLK DDR
// command slots, so the count is resolved to a slot within the fabric cycle.
// The command picker gates issue with done[i] and places the command in slot
// offset[i].
//
// Ports
//   clk      in   1                  fabric clock, the only clock
//   rst      in   1                  synchronous active-high reset
//   cfg_we   in   1                  write a constraint length
//   cfg_idx  in   IDX_W              tracker written; indices >= NUM_CTR ignored
//   cfg_tck  in   CTR_W              new constraint length in DDR cycles
//   start    in   NUM_CTR            per-tracker start (triggering command issues)
//   slot     in   SLOT_W             slot of the triggering command
//   clear    in   NUM_CTR            per-tracker abort to the satisfied state
//   done     out  NUM_CTR            constraint satisfied within this fabric cycle
//   offset   out  NUM_CTR*SLOT_W     earliest legal slot, tracker i at [i*SLOT_W +: SLOT_W]
//   all_done out  1                  AND of done
// -----------------------------------------------------------------------------
module timing_counter_bank #(
  parameter int nCK_PER_CLK = 4,
  parameter int NUM_CTR     = 8,
  parameter int CTR_W       = 8,
  parameter int DEFAULT_TCK = 14,
  parameter bit EXTEND_ONLY = 1'b1,
  localparam int SLOT_W     = $clog2(nCK_PER_CLK),
  localparam int IDX_W      = (NUM_CTR > 1) ? $clog2(NUM_CTR) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_idx,
  input  logic [CTR_W-1:0]            cfg_tck,
  input  logic [NUM_CTR-1:0]          start,
  input  logic [SLOT_W-1:0]           slot,
  input  logic [NUM_CTR-1:0]          clear,
  output logic [NUM_CTR-1:0]          done,
  output logic [NUM_CTR*SLOT_W-1:0]   offset,
  output logic                        all_done
);

  // DDR cycles consumed per fabric cycle, in unsigned and signed load widths.
  localparam logic        [CTR_W-1:0] NCK_U    = CTR_W'(nCK_PER_CLK);
  localparam logic signed [CTR_W+1:0] NCK_S    = (CTR_W+2)'(nCK_PER_CLK);
  localparam logic signed [CTR_W+1:0] LOAD_MAX = {2'b00, {CTR_W{1'b1}}};

  for (genvar g = 0; g < NUM_CTR; g++) begin : g_ctr
    logic        [CTR_W-1:0] tck;
    logic        [CTR_W-1:0] rem;
    logic signed [CTR_W+1:0] load_raw;
    logic        [CTR_W-1:0] load;
    logic        [CTR_W-1:0] dec;
    logic        [CTR_W-1:0] start_val;

    // The command sits 'slot' DDR cycles into this fabric cycle, and rem is
    // referenced to the start of the next one, hence tck + slot - nCK_PER_CLK.
    // The two extra bits hold both the negative case (short tck) and the
    // overflow above the counter range.
    // NOTE: every always_comb output is assigned on every path (defaults
    // first) so no latch is inferred.
    always_comb begin
      load_raw = $signed({2'b00, tck})
               + $signed({{(CTR_W+2-SLOT_W){1'b0}}, slot})
               - NCK_S;
      load = '0;
      if (load_raw < 0)
        load = '0;
      else if (load_raw > LOAD_MAX)
        load = '1;
      else
        load = load_raw[CTR_W-1:0];
    end

    // Free-running decrement, floored at zero so a satisfied tracker stays put.
    always_comb begin
      dec = '0;
      if (rem >= NCK_U)
        dec = rem - NCK_U;
    end

    // In extend-only mode a new command never shortens a constraint that an
    // earlier command is still enforcing.
    always_comb begin
      start_val = load;
      if (EXTEND_ONLY && (dec > load))
        start_val = dec;
    end

    // Start outranks clear: a command issued in the same cycle as an abort
    // still imposes its own constraint. A config write in the same cycle as a
    // start lands after the load, so the load sees the old tck.
    // NOTE: state registers use non-blocking assignments so every tracker
    // updates from the same pre-edge values.
    always_ff @(posedge clk) begin
      if (rst) begin
        rem <= '0;
        tck <= CTR_W'(DEFAULT_TCK);
      end else begin
        if (start[g])
          rem <= start_val;
        else if (clear[g])
          rem <= '0;
        else
          rem <= dec;

        if (cfg_we && (cfg_idx == IDX_W'(g)))
          tck <= cfg_tck;
      end
    end

    // Once rem fits inside one fabric cycle, its value is the slot index.
    assign done[g]                     = (rem < NCK_U);
    assign offset[g*SLOT_W +: SLOT_W]  = rem[SLOT_W-1:0];
  end

  assign all_done = &done;

endmodule

// File: tb/tb_timing_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_timing_counter_bank
//
// Drives two copies of timing_counter_bank with identical stimulus, one built
// with EXTEND_ONLY = 1 (dut_x) and one with EXTEND_ONLY = 0 (dut_n). The
// reference model tracks, per tracker, the absolute DDR cycle at which the
// constraint is met (a deadline); expected rem in fabric cycle c is that
// deadline minus 4c, floored at zero.
// -----------------------------------------------------------------------------
module tb_timing_counter_bank;

  localparam int NCK = 4;
  localparam int NC  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [7:0]  cfg_tck;
  logic [7:0]  start;
  logic [1:0]  slot;
  logic [7:0]  clear;
  logic [7:0]  done_x, done_n;
  logic [15:0] off_x, off_n;
  logic        all_x, all_n;

  always #5 clk = ~clk;

  timing_counter_bank #(.EXTEND_ONLY(1'b1)) dut_x (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tck(cfg_tck),
    .start(start), .slot(slot), .clear(clear),
    .done(done_x), .offset(off_x), .all_done(all_x)
  );

  timing_counter_bank #(.EXTEND_ONLY(1'b0)) dut_n (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_tck(cfg_tck),
    .start(start), .slot(slot), .clear(clear),
    .done(done_n), .offset(off_n), .all_done(all_n)
  );

  // Model state: deadline[m][i] in absolute DDR cycles, m = 1 extend-only.
  longint dl [2][NC];
  int     tck_m [NC];
  longint cyc;
  int     checks;
  int     errors;

  function automatic int exp_rem(int m, int i);
    longint r;
    r = dl[m][i] - longint'(NCK) * cyc;
    if (r < 0) r = 0;
    return int'(r);
  endfunction

  function automatic logic get_done(int m, int i);
    logic [7:0] v;
    v = (m == 1) ? done_x : done_n;
    return v[i];
  endfunction

  function automatic logic [1:0] get_off(int m, int i);
    logic [15:0] v;
    v = (m == 1) ? off_x : off_n;
    return v[i*2 +: 2];
  endfunction

  function automatic logic get_all(int m);
    return (m == 1) ? all_x : all_n;
  endfunction

  // Advance one fabric cycle: update the model from the inputs sampled at this
  // edge, then release the single-cycle pulses.
  task automatic tick();
    longint base, nd;
    @(posedge clk);
    base = longint'(NCK) * (cyc + 1);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NC; i++) begin
        if (rst) begin
          dl[m][i] = 0;
        end else if (start[i]) begin
          nd = longint'(NCK) * cyc + slot + tck_m[i];
          if (nd < base) nd = base;
          if (nd > base + 255) nd = base + 255;
          if (m == 1 && dl[m][i] > nd) nd = dl[m][i];
          dl[m][i] = nd;
        end else if (clear[i]) begin
          dl[m][i] = 0;
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < NC; i++) tck_m[i] = 14;
    end else if (cfg_we) begin
      tck_m[cfg_idx] = cfg_tck;
    end
    cyc++;
    #1;
    start  = '0;
    clear  = '0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    int exp_o;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (((m == 1) ? done_x : done_n) !== 8'hFF) begin
        errors++;
        $display("FAIL reset_done m%0d: got %h expected ff", m, (m == 1) ? done_x : done_n);
      end
      checks++;
      if (get_all(m) !== 1'b1) begin
        errors++;
        $display("FAIL reset_all_done m%0d: got %b expected 1", m, get_all(m));
      end
      checks++;
      if (((m == 1) ? off_x : off_n) !== 16'h0000) begin
        errors++;
        $display("FAIL reset_offset m%0d: got %h expected 0000", m, (m == 1) ? off_x : off_n);
      end
    end
    // Default tck 14 from slot 0: rem 10, 6, 2.
    slot = 2'd0;
    start[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_o = (k == 2) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (get_done(m, 0) !== exp_o[0]) begin
          errors++;
          $display("FAIL reset_default_done m%0d k%0d: got %b expected %0d", m, k, get_done(m, 0), exp_o);
        end
        checks++;
        if (get_off(m, 0) !== 2'd2) begin
          errors++;
          $display("FAIL reset_default_off m%0d k%0d: got %0d expected 2", m, k, get_off(m, 0));
        end
      end
    end
  endtask

  task automatic test_basic();
    int exp_d;
    slot = 2'd1;
    start[3] = 1'b1;
    // rem 11, 7, 3
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_d = (k == 2) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (get_done(m, 3) !== exp_d[0]) begin
          errors++;
          $display("FAIL basic_done m%0d k%0d: got %b expected %0d", m, k, get_done(m, 3), exp_d);
        end
        checks++;
        if (get_all(m) !== exp_d[0]) begin
          errors++;
          $display("FAIL basic_all_done m%0d k%0d: got %b expected %0d", m, k, get_all(m), exp_d);
        end
        checks++;
        if (get_off(m, 3) !== 2'd3) begin
          errors++;
          $display("FAIL basic_off m%0d k%0d: got %0d expected 3", m, k, get_off(m, 3));
        end
      end
    end
  endtask

  task automatic test_short_sat();
    int exp_d;
    int tcks [2] = '{2, 0};
    int slots [2] = '{0, 3};
    for (int t = 0; t < 2; t++) begin
      cfg_we = 1'b1; cfg_idx = 3'd1; cfg_tck = 8'(tcks[t]);
      tick();
      slot = 2'(slots[t]);
      start[1] = 1'b1;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (get_done(m, 1) !== 1'b1 || get_off(m, 1) !== 2'd0) begin
          errors++;
          $display("FAIL short_tck%0d m%0d: got done %b off %0d expected done 1 off 0",
                   tcks[t], m, get_done(m, 1), get_off(m, 1));
        end
      end
    end
    // Longest length, slot 3: load 254, done after 63 more cycles at offset 2.
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_tck = 8'd255;
    tick();
    slot = 2'd3;
    start[1] = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      exp_d = (k == 63) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (get_done(m, 1) !== exp_d[0]) begin
          errors++;
          $display("FAIL long_done m%0d k%0d: got %b expected %0d", m, k, get_done(m, 1), exp_d);
        end
        checks++;
        if (get_off(m, 1) !== 2'(exp_rem(m, 1))) begin
          errors++;
          $display("FAIL long_off m%0d k%0d: got %0d expected %0d", m, k, get_off(m, 1), exp_rem(m, 1) % 4);
        end
      end
      if (k == 63) begin
        checks++;
        if (get_off(1, 1) !== 2'd2) begin
          errors++;
          $display("FAIL long_final_off: got %0d expected 2", get_off(1, 1));
        end
      end
      if (k < 63) tick();
    end
  endtask

  task automatic test_extend();
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_tck = 8'd20;
    tick();
    slot = 2'd0;
    start[2] = 1'b1;
    tick();                                   // rem 16
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_tck = 8'd6;
    tick();                                   // rem 12
    start[2] = 1'b1;
    tick();                                   // extend: 8, replace: 2
    checks++;
    if (get_done(0, 2) !== 1'b1 || get_off(0, 2) !== 2'd2) begin
      errors++;
      $display("FAIL replace_rem: got done %b off %0d expected done 1 off 2", get_done(0, 2), get_off(0, 2));
    end
    checks++;
    if (get_done(1, 2) !== 1'b0) begin
      errors++;
      $display("FAIL extend_rem8: got done %b expected 0", get_done(1, 2));
    end
    tick();                                   // extend: 4
    checks++;
    if (get_done(1, 2) !== 1'b0) begin
      errors++;
      $display("FAIL extend_rem4: got done %b expected 0", get_done(1, 2));
    end
    tick();                                   // extend: 0
    checks++;
    if (get_done(1, 2) !== 1'b1 || get_off(1, 2) !== 2'd0) begin
      errors++;
      $display("FAIL extend_rem0: got done %b off %0d expected done 1 off 0", get_done(1, 2), get_off(1, 2));
    end
  endtask

  task automatic test_simul();
    int exp_d;
    slot = 2'd0;
    start[4] = 1'b1;
    clear[4] = 1'b1;
    cfg_we = 1'b1; cfg_idx = 3'd4; cfg_tck = 8'd30;
    // Old tck 14 wins: rem 10, 6, 2.
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_d = (k == 2) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (get_done(m, 4) !== exp_d[0] || get_off(m, 4) !== 2'd2) begin
          errors++;
          $display("FAIL simul_old_tck m%0d k%0d: got done %b off %0d expected done %0d off 2",
                   m, k, get_done(m, 4), get_off(m, 4), exp_d);
        end
      end
    end
    // New tck 30 now applies: rem 26, 22, ... 2.
    start[4] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      exp_d = (k == 6) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (get_done(m, 4) !== exp_d[0] || get_off(m, 4) !== 2'd2) begin
          errors++;
          $display("FAIL simul_new_tck m%0d k%0d: got done %b off %0d expected done %0d off 2",
                   m, k, get_done(m, 4), get_off(m, 4), exp_d);
        end
      end
    end
  endtask

  task automatic test_clear_reset();
    slot = 2'd3;
    start[5] = 1'b1;
    start[6] = 1'b1;
    tick();                                   // rem 13
    tick();                                   // rem 9
    clear[5] = 1'b1;
    tick();                                   // tracker 5 cleared, tracker 6 at 5
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (get_done(m, 5) !== 1'b1 || get_off(m, 5) !== 2'd0) begin
        errors++;
        $display("FAIL clear_t5 m%0d: got done %b off %0d expected done 1 off 0", m, get_done(m, 5), get_off(m, 5));
      end
      checks++;
      if (get_done(m, 6) !== 1'b0 || get_off(m, 6) !== 2'd1) begin
        errors++;
        $display("FAIL clear_t6_untouched m%0d: got done %b off %0d expected done 0 off 1", m, get_done(m, 6), get_off(m, 6));
      end
    end
    // Reset mid-count; start, clear and cfg in the reset cycle are ignored.
    slot = 2'd0;
    start = 8'hFF;
    tick();
    rst = 1'b1;
    start = 8'hFF;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_tck = 8'd0;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (((m == 1) ? done_x : done_n) !== 8'hFF || get_all(m) !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset m%0d: got done %h all %b expected ff 1", m, (m == 1) ? done_x : done_n, get_all(m));
      end
    end
    start[0] = 1'b1;
    start[4] = 1'b1;
    tick();                                   // both back at default 14: rem 10
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (get_done(m, 0) !== 1'b0 || get_off(m, 0) !== 2'd2) begin
        errors++;
        $display("FAIL post_reset_t0 m%0d: got done %b off %0d expected done 0 off 2", m, get_done(m, 0), get_off(m, 0));
      end
      checks++;
      if (get_done(m, 4) !== 1'b0 || get_off(m, 4) !== 2'd2) begin
        errors++;
        $display("FAIL post_reset_t4 m%0d: got done %b off %0d expected done 0 off 2", m, get_done(m, 4), get_off(m, 4));
      end
    end
  endtask

  task automatic test_random();
    logic exp_all;
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 149) == 0);
      slot = 2'($urandom_range(0, 3));
      for (int i = 0; i < NC; i++) begin
        start[i] = ($urandom_range(0, 5) == 0);
        clear[i] = ($urandom_range(0, 11) == 0);
      end
      cfg_we  = ($urandom_range(0, 3) == 0);
      cfg_idx = 3'($urandom_range(0, 7));
      cfg_tck = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                           : 8'($urandom_range(0, 40));
      tick();
      for (int m = 0; m < 2; m++) begin
        exp_all = 1'b1;
        for (int i = 0; i < NC; i++) begin
          exp_all = exp_all & (exp_rem(m, i) < NCK);
          checks++;
          if (get_done(m, i) !== (exp_rem(m, i) < NCK)) begin
            errors++;
            $display("FAIL rand_done m%0d n%0d t%0d: got %b expected %b (rem %0d)",
                     m, n, i, get_done(m, i), exp_rem(m, i) < NCK, exp_rem(m, i));
          end
          checks++;
          if (get_off(m, i) !== 2'(exp_rem(m, i))) begin
            errors++;
            $display("FAIL rand_off m%0d n%0d t%0d: got %0d expected %0d",
                     m, n, i, get_off(m, i), exp_rem(m, i) % 4);
          end
        end
        checks++;
        if (get_all(m) !== exp_all) begin
          errors++;
          $display("FAIL rand_all_done m%0d n%0d: got %b expected %b", m, n, get_all(m), exp_all);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_tck = '0;
    start  = '0;   slot = '0;    clear = '0;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NC; i++) dl[m][i] = 0;
    for (int i = 0; i < NC; i++) tck_m[i] = 14;
    #2;
    test_reset();
    test_basic();
    test_short_sat();
    test_extend();
    test_simul();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
